status_source: RTL and testbench

- Transmit-side counterpart of the pipeline's AXI-Stream status channel.
- Accumulates per-frame event flags from the GCC-PHAT datapath (overflow, unexpected tlast, saturation, etc.) between frame boundaries.
- At each frame boundary, packs the accumulated flags with a frame sequence number into one WIDTH-bit status word and emits it on m_axis_status with full AXIS handshake.
- A 2-entry output queue absorbs downstream backpressure. Loss is counted, never silent.

---
 rtl/status_source.sv | 138 +++++++++++++
 tb/tb_status_source.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/status_source.sv
// Frame status emitter: ORs event pulses per frame, emits {flags, seq} on AXIS at frame_done.
// Latency 1 cycle from frame_done to tvalid; a 2-deep queue absorbs stalls, overflow is counted.

module status_fifo #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] wr_dat,
  input  logic         wr_vld,
  output logic         wr_rdy,
  output logic [W-1:0] rd_dat,
  output logic         rd_vld,
  input  logic         rd_rdy
);

  logic [W-1:0] slot0;
  logic [W-1:0] slot1;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  assign rd_dat = slot0;
  assign rd_vld = (count != 2'd0);
  // A full queue still takes a word when the head leaves in the same cycle.
  assign wr_rdy = (count != 2'd2) | rd_rdy;
  assign push   = wr_vld & wr_rdy;
  assign pop    = rd_vld & rd_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= wr_dat;
          else               slot1 <= wr_dat;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            slot0 <= wr_dat;
          end else begin
            slot0 <= slot1;
            slot1 <= wr_dat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

module status_source #(
  parameter int WIDTH = 24,
  parameter int EVT_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [EVT_W-1:0] evt_flags,
  input  logic             frame_done,
  input  logic             lost_clear,
  output logic [WIDTH-1:0] m_axis_status_tdata,
  output logic             m_axis_status_tvalid,
  input  logic             m_axis_status_tready,
  output logic             status_lost,
  output logic [7:0]       lost_count
);

  if (WIDTH != EVT_W + CNT_W) begin : g_bad_width
    $error("status_source: WIDTH must equal EVT_W + CNT_W");
  end

  logic [EVT_W-1:0] acc;
  logic [EVT_W-1:0] flags_next;
  logic [CNT_W-1:0] seq;
  logic             push_rdy;
  logic             accept;
  logic             drop;

  // Same-cycle flags belong to the frame that is closing.
  assign flags_next = acc | evt_flags;
  assign accept     = frame_done & push_rdy;
  assign drop       = frame_done & ~push_rdy;

  status_fifo #(.W(WIDTH)) u_queue (
    .clk    (aclk),
    .rst_n  (aresetn),
    .wr_dat ({flags_next, seq}),
    .wr_vld (frame_done),
    .wr_rdy (push_rdy),
    .rd_dat (m_axis_status_tdata),
    .rd_vld (m_axis_status_tvalid),
    .rd_rdy (m_axis_status_tready)
  );

  // A dropped word keeps its flags in acc so they surface in the next word.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc <= '0;
    end else if (accept) begin
      acc <= '0;
    end else begin
      acc <= flags_next;
    end
  end

  // seq advances on every boundary so drops appear as gaps downstream.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      seq <= '0;
    end else if (frame_done) begin
      seq <= seq + CNT_W'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      status_lost <= 1'b0;
      lost_count  <= 8'd0;
    end else if (lost_clear) begin
      status_lost <= 1'b0;
      lost_count  <= 8'd0;
    end else if (drop) begin
      status_lost <= 1'b1;
      if (lost_count != 8'hFF) lost_count <= lost_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_status_source.sv
// Directed bench for status_source: stimulus pushes expected words, a negedge monitor pops and compares.
module tb_status_source;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [7:0]  evt_flags = 8'h00;
  logic        frame_done = 1'b0;
  logic        lost_clear = 1'b0;
  logic [23:0] tdata;
  logic        tvalid;
  logic        tready = 1'b1;
  logic        status_lost;
  logic [7:0]  lost_count;

  int errors = 0;
  int checks = 0;
  logic [23:0] exp_q[$];

  always #5 aclk = ~aclk;

  status_source #(.WIDTH(24), .EVT_W(8), .CNT_W(16)) dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .evt_flags            (evt_flags),
    .frame_done           (frame_done),
    .lost_clear           (lost_clear),
    .m_axis_status_tdata  (tdata),
    .m_axis_status_tvalid (tvalid),
    .m_axis_status_tready (tready),
    .status_lost          (status_lost),
    .lost_count           (lost_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs are applied just after a rising edge and held for one full cycle.
  task automatic drive(input logic [7:0] f, input logic fd, input logic clr);
    evt_flags  = f;
    frame_done = fd;
    lost_clear = clr;
    @(posedge aclk);
    #1;
    evt_flags  = 8'h00;
    frame_done = 1'b0;
    lost_clear = 1'b0;
  endtask

  task automatic frame(input logic [7:0] f, input logic [23:0] exp_word);
    exp_q.push_back(exp_word);
    drive(f, 1'b1, 1'b0);
  endtask

  task automatic wait_empty(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge aclk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d words outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: compare each handshaked word against the scoreboard, and check stall stability.
  initial begin
    logic        stalled;
    logic [23:0] held;
    logic [23:0] e;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        stalled = 1'b0;
      end else begin
        if (stalled && tvalid) chk("tdata_stable", {8'h00, tdata}, {8'h00, held});
        if (tvalid && tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %h expected none", tdata);
          end else begin
            e = exp_q.pop_front();
            chk("word", {8'h00, tdata}, {8'h00, e});
          end
        end
        stalled = tvalid && !tready;
        held = tdata;
      end
    end
  end

  initial begin
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
    chk("rst_tdata", {8'h00, tdata}, 32'd0);
    chk("rst_lost", {31'd0, status_lost}, 32'd0);
    chk("rst_count", {24'd0, lost_count}, 32'd0);
    aresetn = 1'b1;

    // Basic framing and one-cycle latency.
    drive(8'h00, 1'b0, 1'b0);
    drive(8'h01, 1'b0, 1'b0);
    drive(8'h00, 1'b0, 1'b0);
    frame(8'h00, 24'h010000);
    chk("latency_tvalid", {31'd0, tvalid}, 32'd1);
    chk("latency_tdata", {8'h00, tdata}, 32'h010000);
    frame(8'h00, 24'h000001);
    wait_empty(20);

    // Flags coincident with frame_done merge into the closing frame.
    drive(8'h04, 1'b0, 1'b0);
    frame(8'h80, 24'h840002);
    frame(8'h00, 24'h000003);
    wait_empty(20);

    // Overflow drop, flags carried forward, gap in seq.
    tready = 1'b0;
    frame(8'h01, 24'h010004);
    frame(8'h02, 24'h020005);
    drive(8'h04, 1'b1, 1'b0);
    chk("drop_count", {24'd0, lost_count}, 32'd1);
    chk("drop_lost", {31'd0, status_lost}, 32'd1);
    chk("drop_head", {8'h00, tdata}, 32'h010004);
    tready = 1'b1;
    frame(8'h00, 24'h040007);
    chk("full_pop_no_drop", {24'd0, lost_count}, 32'd1);
    wait_empty(20);

    // Stall with a full queue, then push and pop in the same cycle.
    tready = 1'b0;
    frame(8'h10, 24'h100008);
    frame(8'h20, 24'h200009);
    repeat (3) drive(8'h00, 1'b0, 1'b0);
    chk("stall_head", {8'h00, tdata}, 32'h100008);
    tready = 1'b1;
    frame(8'h40, 24'h40000A);
    chk("full_pop_count", {24'd0, lost_count}, 32'd1);
    wait_empty(20);

    // lost_clear, and clear winning over a simultaneous drop.
    drive(8'h00, 1'b0, 1'b1);
    chk("clear_lost", {31'd0, status_lost}, 32'd0);
    chk("clear_count", {24'd0, lost_count}, 32'd0);
    tready = 1'b0;
    frame(8'h00, 24'h00000B);
    frame(8'h00, 24'h00000C);
    drive(8'h00, 1'b1, 1'b1);
    chk("clear_vs_drop_lost", {31'd0, status_lost}, 32'd0);
    chk("clear_vs_drop_count", {24'd0, lost_count}, 32'd0);
    tready = 1'b1;
    wait_empty(20);

    // Sequence wrap from a fresh reset.
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      logic [15:0] s;
      s = 16'(i);
      frame(8'h00, {8'h00, s});
    end
    frame(8'h55, 24'h55FFFF);
    frame(8'h00, 24'h000000);
    wait_empty(20);

    // lost_count saturation.
    tready = 1'b0;
    frame(8'h00, 24'h000001);
    frame(8'h00, 24'h000002);
    for (int i = 0; i < 254; i++) drive(8'h00, 1'b1, 1'b0);
    chk("count_254", {24'd0, lost_count}, 32'd254);
    for (int i = 0; i < 44; i++) drive(8'h00, 1'b1, 1'b0);
    chk("count_sat", {24'd0, lost_count}, 32'd255);
    chk("sat_lost", {31'd0, status_lost}, 32'd1);
    drive(8'h00, 1'b0, 1'b1);
    chk("sat_clear_count", {24'd0, lost_count}, 32'd0);
    chk("sat_clear_lost", {31'd0, status_lost}, 32'd0);
    chk("clear_keeps_queue", {31'd0, tvalid}, 32'd1);
    chk("clear_keeps_head", {8'h00, tdata}, 32'h000001);

    // Asynchronous reset while stalled flushes the queue.
    aresetn = 1'b0;
    exp_q.delete();
    #1;
    chk("async_rst_tvalid", {31'd0, tvalid}, 32'd0);
    chk("async_rst_tdata", {8'h00, tdata}, 32'd0);
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    tready = 1'b1;
    repeat (3) drive(8'h00, 1'b0, 1'b0);
    chk("no_stale_word", {31'd0, tvalid}, 32'd0);
    frame(8'h03, 24'h030000);
    wait_empty(20);
    chk("final_idle", {31'd0, tvalid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
